// File: rtl/sys_mem_pkg.sv
// Shared types and sizing helpers for the latency-configurable system-bus memory model.
package sys_mem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    KIND_RD  = 2'd0,
    KIND_WR  = 2'd1,
    KIND_BAD = 2'd2
  } kind_t;

  // Word-index width for a DEPTH-word array (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Number of low address bits that select a byte inside a DW-bit word.
  function automatic int off_width(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/sys_mem_array.sv
// Single-port byte-enabled RAM with a registered read port.
// A write and the read of the same word on one edge return the freshly written data.
import sys_mem_pkg::*;

module sys_mem_array #(
  parameter int DW    = 64,
  parameter int DEPTH = 1024,
  parameter int SW    = DW / 8,
  parameter int IW    = idx_width(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [IW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [SW-1:0] sel,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] merged;

  // Current word with the selected bytes replaced by the incoming write data.
  always_comb begin
    merged = mem[addr];
    for (int i = 0; i < SW; i++) begin
      if (sel[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  // Commit the write and capture the (post-write) word into the read register.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= merged;
      rdata <= we ? merged : mem[addr];
    end
  end

endmodule

// File: rtl/sys_mem_model.sv
// System-bus memory target: range-checked, latency-programmable responses and request counters.
import sys_mem_pkg::*;

module sys_mem_model #(
  parameter int             DW    = 64,
  parameter int             AW    = 32,
  parameter int             SW    = DW / 8,
  parameter int             DEPTH = 1024,
  parameter logic [AW-1:0]  BASE  = 32'h0,
  parameter int             LAT   = 1
) (
  input  logic          axi_clk_i,
  input  logic          axi_rstn_i,
  input  logic [AW-1:0] sys_addr_i,
  input  logic [DW-1:0] sys_wdata_i,
  input  logic [SW-1:0] sys_sel_i,
  input  logic          sys_wen_i,
  input  logic          sys_ren_i,
  output logic [DW-1:0] sys_rdata_o,
  output logic          sys_ack_o,
  output logic          sys_err_o,
  output logic          busy_o,
  output logic [31:0]   wr_cnt_o,
  output logic [31:0]   rd_cnt_o,
  output logic [31:0]   drop_cnt_o
);

  localparam int            IW   = idx_width(DEPTH);
  localparam int            OW   = off_width(DW);
  localparam logic [AW:0]   SPAN = (AW+1)'(DEPTH * SW);

  state_t        state;
  logic [3:0]    cnt;
  kind_t         kind_q;
  kind_t         kind_d;
  logic          req;
  logic          accept;
  logic          in_range;
  logic [AW-1:0] offset;
  logic          arr_en;
  logic [DW-1:0] arr_rdata;

  assign req      = sys_wen_i | sys_ren_i;
  assign accept   = req && (state == ST_IDLE) && axi_rstn_i;
  assign offset   = sys_addr_i - BASE;
  assign in_range = (sys_addr_i >= BASE) && ({1'b0, offset} < SPAN);
  assign arr_en   = accept && (kind_d != KIND_BAD);

  // Classify the request: both strobes together or an address outside the window is an error.
  always_comb begin
    kind_d = KIND_RD;
    if ((sys_wen_i && sys_ren_i) || !in_range) kind_d = KIND_BAD;
    else if (sys_wen_i)                          kind_d = KIND_WR;
  end

  sys_mem_array #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .SW    (SW),
    .IW    (IW)
  ) u_array (
    .clk   (axi_clk_i),
    .en    (arr_en),
    .we    (sys_wen_i),
    .addr  (offset[OW +: IW]),
    .wdata (sys_wdata_i),
    .sel   (sys_sel_i),
    .rdata (arr_rdata)
  );

  // Response FSM: the countdown in WAIT stretches the gap so ack lands exactly LAT cycles after accept.
  always_ff @(posedge axi_clk_i) begin
    if (!axi_rstn_i) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      kind_q <= KIND_RD;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            kind_q <= kind_d;
            if (LAT == 1) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= 4'(LAT - 2);
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request statistics; a request seen while busy is dropped and only counted here.
  always_ff @(posedge axi_clk_i) begin
    if (!axi_rstn_i) begin
      wr_cnt_o   <= '0;
      rd_cnt_o   <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (accept && sys_wen_i && !sys_ren_i) wr_cnt_o <= wr_cnt_o + 32'd1;
      if (accept && sys_ren_i && !sys_wen_i) rd_cnt_o <= rd_cnt_o + 32'd1;
      if (req && (state != ST_IDLE))         drop_cnt_o <= drop_cnt_o + 32'd1;
    end
  end

  assign sys_ack_o   = (state == ST_RESP);
  assign sys_err_o   = sys_ack_o && (kind_q == KIND_BAD);
  assign sys_rdata_o = (sys_ack_o && (kind_q == KIND_RD)) ? arr_rdata : '0;
  assign busy_o      = (state != ST_IDLE);

endmodule
